// File: rtl/rf_spi_link.sv
// SPI master for an RF transceiver: short/long register frames in SPI mode 0,
// a byte FIFO for read results and a sticky, synchronised interrupt flag.
module rf_spi_link #(
   parameter int CLK_DIV         = 4,
   parameter int FIFO_DEPTH      = 16,
   parameter bit INTR_ACTIVE_LOW = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_long,
   input  logic                        cmd_write,
   input  logic [9:0]                  cmd_addr,
   input  logic [7:0]                  cmd_wdata,
   output logic [7:0]                  rd_data,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        fifo_full,
   output logic                        busy,
   output logic                        sck,
   output logic                        cs,
   output logic                        sdi,
   input  logic                        sdo,
   input  logic                        intr_in,
   output logic                        intr_pending,
   input  logic                        intr_ack
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [8:0] DIV_LAST   = 9'(CLK_DIV - 1);
   localparam logic [8:0] GUARD_LAST = 9'(2 * CLK_DIV - 1);
   localparam logic       INTR_IDLE  = INTR_ACTIVE_LOW;

   typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

   state_t      state, state_n;
   logic [8:0]  cnt, cnt_n;
   logic [5:0]  half, half_n, half_last;
   logic [23:0] tx_sr, tx_n;
   logic [7:0]  rx_sr, rx_n;
   logic        is_long, is_long_n, is_read, is_read_n;
   logic        sck_n, cs_n, sdi_n;
   logic        accept, push, pop;

   // Handshakes: a transfer happens on a rising clk edge where valid and ready
   // are both 1; ready never looks at valid, and valid is ignored while busy.
   assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
   assign cmd_ready = (state == IDLE) && !fifo_full;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);
   assign half_last = is_long ? 6'd47 : 6'd31;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         half    <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         is_long <= 1'b0;
         is_read <= 1'b0;
         sck     <= 1'b0;
         cs      <= 1'b1;
         sdi     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         half    <= half_n;
         tx_sr   <= tx_n;
         rx_sr   <= rx_n;
         is_long <= is_long_n;
         is_read <= is_read_n;
         sck     <= sck_n;
         cs      <= cs_n;
         sdi     <= sdi_n;
      end
   end

   // half counts elapsed sck half-periods; odd half means sck is high.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      half_n    = half;
      tx_n      = tx_sr;
      rx_n      = rx_sr;
      is_long_n = is_long;
      is_read_n = is_read;
      sck_n     = sck;
      cs_n      = cs;
      sdi_n     = sdi;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n   = SHIFT;
               cnt_n     = '0;
               half_n    = '0;
               is_long_n = cmd_long;
               is_read_n = !cmd_write;
               if (cmd_long)
                  tx_n = {1'b1, cmd_addr, cmd_write, 4'h0, cmd_write ? cmd_wdata : 8'h00};
               else
                  tx_n = {1'b0, cmd_addr[5:0], cmd_write, cmd_write ? cmd_wdata : 8'h00, 8'h00};
               cs_n  = 1'b0;
               sck_n = 1'b0;
               sdi_n = tx_n[23];
            end
         end
         SHIFT: begin
            if (sck && cnt == '0) rx_n = {rx_sr[6:0], sdo};
            if (cnt == DIV_LAST) begin
               cnt_n  = '0;
               half_n = half + 6'd1;
               if (half == half_last) begin
                  state_n = GUARD;
                  cs_n    = 1'b1;
                  sck_n   = 1'b0;
                  sdi_n   = 1'b0;
                  push    = is_read;
               end else if (half[0]) begin
                  sck_n = 1'b0;
                  tx_n  = {tx_sr[22:0], 1'b0};
                  sdi_n = tx_sr[22];
               end else begin
                  sck_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + 9'd1;
            end
         end
         GUARD: begin
            if (cnt == GUARD_LAST) state_n = IDLE;
            else                   cnt_n   = cnt + 9'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   // rx_n already holds a sample taken on the same edge when CLK_DIV is 1.
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign rd_valid = (fifo_count != '0);
   assign pop      = rd_valid && rd_ready;
   assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   logic sync1, sync2, sync3, intr_edge;

   assign intr_edge = (sync2 != INTR_IDLE) && (sync3 == INTR_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1        <= INTR_IDLE;
         sync2        <= INTR_IDLE;
         sync3        <= INTR_IDLE;
         intr_pending <= 1'b0;
      end else begin
         sync1        <= intr_in;
         sync2        <= sync1;
         sync3        <= sync2;
         intr_pending <= intr_edge || (intr_pending && !intr_ack);
      end
   end
endmodule

// File: tb/tb_rf_spi_link.sv
// Bench for rf_spi_link: instance a (CLK_DIV=4, depth 16) and instance b
// (CLK_DIV=2, depth 4) checked against a cycle-level behavioural model.
module tb_rf_spi_link;
   localparam int   DB      = 2;
   localparam int   DEPTH_B = 4;
   localparam logic INACT   = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
   logic       cmd_long = 1'b0, cmd_write = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic       rd_ready = 1'b0;
   logic       sdo = 1'b0;
   logic       intr_in = 1'b1;
   logic       intr_ack = 1'b0;

   logic       cmd_ready_a, rd_valid_a, fifo_full_a, busy_a, sck_a, cs_a, sdi_a, intr_pending_a;
   logic [7:0] rd_data_a;
   logic [4:0] fifo_count_a;
   logic       cmd_ready_b, rd_valid_b, fifo_full_b, busy_b, sck_b, cs_b, sdi_b, intr_pending_b;
   logic [7:0] rd_data_b;
   logic [2:0] fifo_count_b;

   always #5 clk = ~clk;

   rf_spi_link #(.CLK_DIV(4), .FIFO_DEPTH(16), .INTR_ACTIVE_LOW(1'b1)) u_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
      .cmd_long(cmd_long), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
      .fifo_count(fifo_count_a), .fifo_full(fifo_full_a), .busy(busy_a),
      .sck(sck_a), .cs(cs_a), .sdi(sdi_a), .sdo(sdo),
      .intr_in(intr_in), .intr_pending(intr_pending_a), .intr_ack(intr_ack));

   rf_spi_link #(.CLK_DIV(DB), .FIFO_DEPTH(DEPTH_B), .INTR_ACTIVE_LOW(1'b1)) u_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_long(cmd_long), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
      .fifo_count(fifo_count_b), .fifo_full(fifo_full_b), .busy(busy_b),
      .sck(sck_b), .cs(cs_b), .sdi(sdi_b), .sdo(sdo),
      .intr_in(intr_in), .intr_pending(intr_pending_b), .intr_ack(intr_ack));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] frame_of(input bit lng, input bit wr,
                                            input logic [9:0] addr, input logic [7:0] wd);
      logic [7:0] d;
      d = wr ? wd : 8'h00;
      if (lng) return {1'b1, addr, wr, 4'h0, d};
      return {8'h00, 1'b0, addr[5:0], wr, d};
   endfunction

   // Transceiver model for instance b: replays one response word per frame,
   // changing sdo after each sck fall.
   logic [23:0] drv_resp_q[$];
   int          drv_n_q[$];
   logic [23:0] drv_resp = '0;
   int          drv_n = 16, drv_k = 0;
   logic        drv_pcs = 1'b1, drv_psck = 1'b0;

   always @(posedge clk) begin
      #2;
      if (cs_b) begin
         drv_k = 0;
         sdo   = 1'b0;
      end else begin
         if (drv_pcs) begin
            if (drv_resp_q.size() > 0) begin
               drv_resp = drv_resp_q.pop_front();
               drv_n    = drv_n_q.pop_front();
            end
            drv_k = 0;
         end else if (drv_psck && !sck_b) begin
            drv_k++;
         end
         sdo = (drv_k < drv_n) ? drv_resp[drv_n-1-drv_k] : 1'b0;
      end
      drv_pcs  = cs_b;
      drv_psck = sck_b;
   end

   // Behavioural model of instance b; m_t is cycles since the first SHIFT cycle.
   logic [7:0]  m_q[$];
   int          m_t = -1, m_n = 16;
   logic [23:0] m_frame = '0;
   logic        m_read = 1'b0;
   logic [7:0]  m_byte = '0, cur_byte = '0;
   logic [2:0]  m_hist = {3{INACT}};
   logic        m_pend = 1'b0, m_ready, m_edge;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_t    = -1;
         m_hist = {3{INACT}};
         m_pend = 1'b0;
      end else begin
         m_ready = (m_t < 0) && (m_q.size() < DEPTH_B);
         m_edge  = (m_hist[1] != INACT) && (m_hist[2] == INACT);
         m_pend  = m_edge || (m_pend && !intr_ack);
         m_hist  = {m_hist[1:0], intr_in};
         if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_t >= 0) begin
            m_t++;
            if (m_t == 2*m_n*DB && m_read) m_q.push_back(m_byte);
            if (m_t == 2*m_n*DB + 2*DB) m_t = -1;
         end else if (cmd_valid_b && m_ready) begin
            m_t     = 0;
            m_n     = cmd_long ? 24 : 16;
            m_read  = !cmd_write;
            m_byte  = cur_byte;
            m_frame = frame_of(cmd_long, cmd_write, cmd_addr, cmd_wdata);
         end
      end
   end

   bit m_win;
   int m_k;

   always @(negedge clk) begin
      if (chk_en) begin
         m_win = (m_t >= 0) && (m_t < 2*m_n*DB);
         m_k   = m_win ? m_t / (2*DB) : 0;
         chk("cs", cs_b, !m_win);
         chk("sck", sck_b, m_win && ((m_t / DB) % 2 == 1));
         chk("sdi", sdi_b, m_win ? m_frame[m_n-1-m_k] : 1'b0);
         chk("busy", busy_b, m_t >= 0);
         chk("cmd_ready", cmd_ready_b, (m_t < 0) && (m_q.size() < DEPTH_B));
         chk("fifo_count", fifo_count_b, m_q.size());
         chk("fifo_full", fifo_full_b, m_q.size() == DEPTH_B);
         chk("rd_valid", rd_valid_b, m_q.size() > 0);
         chk("rd_data", rd_data_b, (m_q.size() > 0) ? m_q[0] : 8'h00);
         chk("intr_pending", intr_pending_b, m_pend);
      end
   end

   // Frame capture (sdi at each sck rise) and cs-low length for both instances.
   logic [31:0] cap_a = '0, cap_b = '0;
   int          low_a = 0, low_b = 0, max_cnt_a = 0;
   logic        pcs_a = 1'b1, psck_a = 1'b0, pcs_b = 1'b1, psck_b = 1'b0;

   always @(negedge clk) begin
      if (!cs_a) begin
         if (pcs_a) begin cap_a = '0; low_a = 0; end
         low_a++;
         if (sck_a && !psck_a) cap_a = {cap_a[30:0], sdi_a};
      end
      if (!cs_b) begin
         if (pcs_b) begin cap_b = '0; low_b = 0; end
         low_b++;
         if (sck_b && !psck_b) cap_b = {cap_b[30:0], sdi_b};
      end
      pcs_a = cs_a; psck_a = sck_a; pcs_b = cs_b; psck_b = sck_b;
      if (int'(fifo_count_a) > max_cnt_a) max_cnt_a = int'(fifo_count_a);
   end

   task automatic issue(input bit to_b, input bit lng, input bit wr, input logic [9:0] addr,
                        input logic [7:0] wd, input logic [23:0] resp);
      bit ok;
      int waited;
      cmd_long = lng; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cur_byte = resp[7:0];
      if (to_b) begin
         drv_resp_q.push_back(resp);
         drv_n_q.push_back(lng ? 24 : 16);
         cmd_valid_b = 1'b1;
      end else begin
         cmd_valid_a = 1'b1;
      end
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 3000) begin
         @(negedge clk);
         ok = to_b ? cmd_ready_b : cmd_ready_a;
         @(posedge clk); #1;
         waited++;
      end
      cmd_valid_a = 1'b0;
      cmd_valid_b = 1'b0;
      cmd_long  = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 10'($urandom_range(0, 1023));
      cmd_wdata = 8'($urandom_range(0, 255));
      chk("accepted", ok, 1'b1);
   endtask

   task automatic wait_cs_high(input bit to_b, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((to_b ? cs_b : cs_a) == 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, to_b ? cs_b : cs_a, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      chk(name, rd_data_b, exp);
      chk({name, "_valid"}, rd_valid_b, 1'b1);
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_cs", cs_b, 1'b1);
      chk("rst_sck", sck_b, 1'b0);
      chk("rst_sdi", sdi_b, 1'b0);
      chk("rst_busy", busy_b, 1'b0);
      chk("rst_count", fifo_count_b, 0);
      chk("rst_rd_valid", rd_valid_b, 1'b0);
      chk("rst_rd_data", rd_data_b, 8'h00);
      chk("rst_pending", intr_pending_b, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", cmd_ready_b, 1'b1);

      // Short write on instance a: 0,101010,1 then C3.
      issue(1'b0, 1'b0, 1'b1, 10'h02A, 8'hC3, 24'h0);
      wait_cs_high(1'b0, "a_write_done");
      chk("a_sdi_stream", cap_a[15:0], 16'h55C3);
      chk("a_cs_low_cycles", low_a, 128);
      chk("a_fifo_stays_0", max_cnt_a, 0);

      // Long read on instance b; only the last 8 sdo bits form the result.
      issue(1'b1, 1'b1, 1'b0, 10'h300, 8'hFF, {16'h9E71, 8'h5A});
      wait_cs_high(1'b1, "b_read_done");
      chk("b_header", cap_b[23:8], 16'hE000);
      chk("b_read_zero_data", cap_b[7:0], 8'h00);
      chk("b_cs_low_cycles", low_b, 96);
      chk("b_rd_data", rd_data_b, 8'h5A);
      chk("b_rd_valid", rd_valid_b, 1'b1);
      pop_expect("b_pop_5a", 8'h5A);

      // Five reads into a depth-4 FIFO, wrap-around on the fifth.
      for (int i = 1; i <= 4; i++)
         issue(1'b1, 1'b0, 1'b0, 10'(i), 8'h00, {16'($urandom_range(0, 65535)), 8'(i)});
      fork
         issue(1'b1, 1'b0, 1'b0, 10'h05, 8'h00, {16'hBEEF, 8'h05});
         begin
            n = 0;
            while (fifo_count_b != 3'd4 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            chk("fifo_reached_4", fifo_count_b, 4);
            repeat (2*DB + 2) @(posedge clk);
            #1;
            chk("full_blocks_ready", cmd_ready_b, 1'b0);
            chk("full_flag", fifo_full_b, 1'b1);
            chk("fifth_not_started", cs_b, 1'b1);
            pop_expect("pop_01", 8'h01);
         end
      join
      wait_cs_high(1'b1, "fifth_done");
      pop_expect("pop_02", 8'h02);
      pop_expect("pop_03", 8'h03);
      pop_expect("pop_04", 8'h04);
      pop_expect("pop_05_wrapped", 8'h05);
      chk("drained", fifo_count_b, 0);

      // Pop coinciding with a push at count 2.
      issue(1'b1, 1'b0, 1'b0, 10'h11, 8'h00, 24'h000011);
      wait_cs_high(1'b1, "pp1_done");
      issue(1'b1, 1'b0, 1'b0, 10'h22, 8'h00, 24'h000022);
      wait_cs_high(1'b1, "pp2_done");
      issue(1'b1, 1'b0, 1'b0, 10'h33, 8'h00, 24'h000033);
      repeat (2*16*DB - 1) @(posedge clk);
      #1;
      chk("pp_count_before", fifo_count_b, 2);
      chk("pp_head_before", rd_data_b, 8'h11);
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
      chk("pp_count_after", fifo_count_b, 2);
      chk("pp_cs_rose", cs_b, 1'b1);
      pop_expect("pp_pop_22", 8'h22);
      pop_expect("pp_pop_33", 8'h33);

      // Interrupt: latency, single edge per level, set beats ack.
      repeat (4) @(posedge clk);
      #1;
      intr_in = 1'b0;
      @(posedge clk); #1;
      chk("intr_c1", intr_pending_b, 1'b0);
      @(posedge clk); #1;
      chk("intr_c2", intr_pending_b, 1'b0);
      @(posedge clk); #1;
      chk("intr_c3", intr_pending_b, 1'b1);
      intr_ack = 1'b1;
      @(posedge clk); #1;
      intr_ack = 1'b0;
      chk("intr_acked", intr_pending_b, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("intr_level_once", intr_pending_b, 1'b0);
      intr_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      intr_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      intr_ack = 1'b1;
      @(posedge clk); #1;
      intr_ack = 1'b0;
      chk("intr_set_wins", intr_pending_b, 1'b1);
      intr_ack = 1'b1;
      @(posedge clk); #1;
      intr_ack = 1'b0;
      intr_in = 1'b1;
      chk("intr_cleared", intr_pending_b, 1'b0);

      // Reset in the middle of a long write.
      issue(1'b1, 1'b1, 1'b1, 10'h155, 8'h3C, 24'h0);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_cs", cs_b, 1'b1);
      chk("abort_sck", sck_b, 1'b0);
      chk("abort_busy", busy_b, 1'b0);
      chk("abort_count", fifo_count_b, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_abort", cmd_ready_b, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_push", rd_valid_b, 1'b0);

      chk("a_end_rd_valid", rd_valid_a, 1'b0);
      chk("a_end_rd_data", rd_data_a, 8'h00);
      chk("a_end_full", fifo_full_a, 1'b0);
      chk("a_end_busy", busy_a, 1'b0);
      chk("a_end_ready", cmd_ready_a, 1'b1);
      chk("a_end_pending", intr_pending_a, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
